instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the lab MIPS core, directly upstream of the main control decoder.
//  - Holds the PC and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake.
//  - Presents the instruction and its op_code (instr[31:26]) to the decoder.
//  - Computes the next PC from branch/zero/jump returned by decode/execute.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded at reset
//  MAX_WAIT     16             cycles to wait for imem_ack before timeout (FETCH_TIMEOUT_EN only)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request, held high until imem_ack
//  imem_addr    out  32  byte address of word being fetched (= pc)
//  imem_ack     in   1   memory has valid imem_rdata this cycle
//  imem_rdata   in   32  instruction word
//  branch       in   1   current instr is beq (from decoder)
//  zero         in   1   ALU zero flag for current instr
//  jump         in   1   current instr is j (from decoder)
//  stall        in   1   downstream not ready; hold current instruction
//  instr        out  32  current instruction
//  op_code      out  6   instr[31:26], to decoder
//  instr_valid  out  1   instr/op_code valid for decode
//  pc           out  32  address of current instruction
//  fetch_err    out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0.
//  FSM:
//   - IDLE -> REQ: unconditionally, first clock after reset release.
//   - REQ: imem_req=1, imem_addr=pc. ack same cycle -> latch instr, go HOLD; else -> WAIT.
//   - WAIT: imem_req=1, addr stable. ack -> latch instr, go HOLD.
//   - HOLD: instr_valid=1, instr stable.
//     - stall=1: remain in HOLD; pc/instr unchanged.
//     - stall=0: pc <= next_pc, instr_valid <= 0, go REQ.
//  Next PC (pc_plus4 = pc+4, 32-bit wrap; 32'hFFFF_FFFC+4 = 0):
//   - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
//   - else branch&zero: pc_plus4 + ({{14{instr[15]}},instr[15:0],2'b00}), modulo 2^32.
//   - else: pc_plus4.
//   - jump and branch both high: jump wins.
//   - branch/zero/jump sampled only in HOLD with stall=0; ignored in all other states.
//  Timing:
//   - Latency: zero-wait memory gives instr_valid 2 cycles after imem_req rises.
//   - Throughput: one instr per 3 cycles with no stall.
//  Handshake:
//   - imem_ack outside REQ/WAIT is ignored.
//   - imem_req never drops before ack (or timeout).
//  Reset mid-operation: aborts any pending request immediately; imem_req falls asynchronously.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - Counter clears on entering REQ and increments each cycle in WAIT.
//   - Counter reaching MAX_WAIT: fetch_err <= 1 (sticky until reset), drop req one cycle, re-enter REQ at same pc.
//  FETCH_TIMEOUT_EN undefined:
//   - WAIT unbounded; no counter logic; fetch_err tied 0.
// TESTING
//  1. Reset low, RESET_PC=0x40 -> imem_req=0, pc=0x40, instr_valid=0; after release, req with addr 0x40.
//  2. Zero-wait memory, three plain R-type words -> addresses 0x40, 0x44, 0x48; instr_valid pulses each 3 cycles.
//  3. beq imm=0xFFFF, branch=1, zero=1 at pc=0x48 -> next addr 0x48; zero=0 -> 0x4C.
//  4. j target 26'h0000100 at pc=0x1000_0000 -> next addr 0x1000_0400; jump+branch both 1 -> jump target used.
//  5. stall=1 for 5 cycles in HOLD -> instr, pc, instr_valid stable, no imem_req; release -> fetch next.
//  6. FETCH_TIMEOUT_EN, MAX_WAIT=4, no ack -> fetch_err=1 after 4 WAIT cycles, req re-issued at same pc;
//     ack then -> normal HOLD, fetch_err stays 1.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage of the lab MIPS core: holds the PC, fetches one word per instruction over
// a req/ack handshake and resolves the next PC. Optional ack timeout: `define FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} stateT;

    stateT       state;
    stateT       nextState;
    logic [31:0] pcReg;
    logic [31:0] pcNext;
    logic [31:0] instrReg;
    logic [31:0] instrNext;
    logic        validReg;
    logic        validNext;
    logic        reqReg;
    logic        reqNext;
    logic        timeoutHit;
    logic [31:0] pcPlus4;
    logic [31:0] branchOff;
    logic [31:0] targetPc;

    if (MAX_WAIT == 0) begin : gBadMaxWait
        $error("instr_fetch: MAX_WAIT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] waitCnt;
    logic            errReg;

    // Counter is zero in REQ and counts WAIT cycles; hitting the limit retries via IDLE.
    assign timeoutHit = (state == WAIT) && !imem_ack && (waitCnt == CntW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
            errReg  <= 1'b0;
        end else begin
            waitCnt <= (state == WAIT) ? waitCnt + CntW'(1) : '0;
            errReg  <= errReg | timeoutHit;
        end
    end

    assign fetch_err = errReg;
`else
    assign timeoutHit = 1'b0;
    assign fetch_err  = 1'b0;
`endif

    // Next-PC resolution; jump has priority over a taken branch.
    always_comb begin
        pcPlus4   = pcReg + 32'd4;
        branchOff = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
        if (jump) begin
            targetPc = {pcPlus4[31:28], instrReg[25:0], 2'b00};
        end else if (branch && zero) begin
            targetPc = pcPlus4 + branchOff;
        end else begin
            targetPc = pcPlus4;
        end
    end

    // The first HOLD cycle registers the word; instr_valid rises on the second, so a
    // zero-wait fetch shows valid two cycles after req and repeats every three cycles.
    always_comb begin
        nextState = state;
        pcNext    = pcReg;
        instrNext = instrReg;
        validNext = validReg;
        reqNext   = 1'b0;
        case (state)
            IDLE: begin
                nextState = REQ;
                reqNext   = 1'b1;
            end
            REQ: begin
                if (imem_ack) begin
                    instrNext = imem_rdata;
                    nextState = HOLD;
                end else begin
                    nextState = WAIT;
                    reqNext   = 1'b1;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    instrNext = imem_rdata;
                    nextState = HOLD;
                end else if (timeoutHit) begin
                    nextState = IDLE;
                end else begin
                    reqNext = 1'b1;
                end
            end
            HOLD: begin
                if (!validReg) begin
                    validNext = 1'b1;
                end else if (!stall) begin
                    pcNext    = targetPc;
                    validNext = 1'b0;
                    nextState = REQ;
                    reqNext   = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pcReg    <= RESET_PC;
            instrReg <= '0;
            validReg <= 1'b0;
            reqReg   <= 1'b0;
        end else begin
            state    <= nextState;
            pcReg    <= pcNext;
            instrReg <= instrNext;
            validReg <= validNext;
            reqReg   <= reqNext;
        end
    end

    assign imem_req    = reqReg;
    assign imem_addr   = pcReg;
    assign pc          = pcReg;
    assign instr       = instrReg;
    assign op_code     = instrReg[31:26];
    assign instr_valid = validReg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {pc, instr} pushed per fetch, monitor pops on instr_valid.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, branch, zero, jump, stall, instr_valid, fetch_err;
    logic [31:0] imem_addr, imem_rdata, instr, pc;
    logic [5:0]  op_code;

    logic        reset1, imem_req1, imem_ack1, branch1, zero1, jump1, stall1, instr_valid1, fetch_err1;
    logic [31:0] imem_addr1, imem_rdata1, instr1, pc1;
    logic [5:0]  op_code1;

    logic        ackEn, forceAck;
    int          ackWait;
    int          reqCycles;
    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } expEntryT;

    expEntryT expQ[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC), .MAX_WAIT(4)) u0 (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch(branch), .zero(zero),
        .jump(jump), .stall(stall), .instr(instr), .op_code(op_code),
        .instr_valid(instr_valid), .pc(pc), .fetch_err(fetch_err)
    );

    instr_fetch #(.RESET_PC(32'h1000_0000), .MAX_WAIT(4)) u1 (
        .clk(clk), .reset(reset1), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ack(imem_ack1), .imem_rdata(imem_rdata1), .branch(branch1), .zero(zero1),
        .jump(jump1), .stall(stall1), .instr(instr1), .op_code(op_code1),
        .instr_valid(instr_valid1), .pc(pc1), .fetch_err(fetch_err1)
    );

    // Memory model: ack after ackWait cycles of req; forceAck acks regardless of req.
    always @(posedge clk or negedge reset) begin
        if (!reset) reqCycles <= 0;
        else if (imem_req && !imem_ack) reqCycles <= reqCycles + 1;
        else reqCycles <= 0;
    end
    assign imem_ack    = forceAck || (ackEn && imem_req && (reqCycles >= ackWait));
    assign imem_rdata  = forceAck ? 32'hDEAD_BEEF : mem[imem_addr[11:2]];
    assign imem_ack1   = imem_req1;
    assign imem_rdata1 = (imem_addr1 == 32'h1000_0000) ? 32'h0800_0100 : 32'h0000_0000;

    function automatic logic [31:0] memAt(input logic [31:0] addr);
        return mem[addr[11:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every rising instr_valid consumes one scoreboard entry.
    logic prevValid = 1'b0;
    always @(negedge clk) begin
        expEntryT m;
        if (reset && instr_valid && !prevValid) begin
            if (expQ.size() == 0) begin
                check("unexpected instr_valid", pc, 32'hFFFF_FFFF);
            end else begin
                m = expQ.pop_front();
                check("scoreboard pc", pc, m.pc);
                check("scoreboard instr", instr, m.instr);
                check("scoreboard op_code", 32'(op_code), 32'(m.instr[31:26]));
            end
        end
        prevValid = reset && instr_valid;
    end

    task automatic awaitValid(input int expWait, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 40);
        check({name, " valid"}, 32'(instr_valid), 32'd1);
        check({name, " latency"}, 32'(n), 32'(expWait));
    endtask

    task automatic finishInstr(input logic [31:0] expPc, input logic [31:0] expInstr,
                               input logic br, input logic zr, input logic jp,
                               input int stallCyc, input string name);
        branch = br;
        zero   = zr;
        jump   = jp;
        if (stallCyc > 0) begin
            stall    = 1'b1;
            forceAck = 1'b1;
            for (int i = 0; i < stallCyc; i++) begin
                @(negedge clk);
                check({name, " stall instr"}, instr, expInstr);
                check({name, " stall pc"}, pc, expPc);
                check({name, " stall valid"}, 32'(instr_valid), 32'd1);
                check({name, " stall req"}, 32'(imem_req), 32'd0);
            end
            forceAck = 1'b0;
            stall    = 1'b0;
        end
        @(posedge clk);
        #1;
        branch = 1'b0;
        zero   = 1'b0;
        jump   = 1'b0;
    endtask

    task automatic fetchStep(input logic [31:0] expPc, input int ackW, input int expWait,
                             input logic br, input logic zr, input logic jp,
                             input int stallCyc, input string name);
        expEntryT e;
        ackWait = ackW;
        e.pc    = expPc;
        e.instr = memAt(expPc);
        expQ.push_back(e);
        awaitValid(expWait, name);
        finishInstr(expPc, e.instr, br, zr, jp, stallCyc, name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        expEntryT e;
        int n;
        int reqHigh;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0020;
        mem[16]  = 32'h012A_4020;   // 0x040 add
        mem[17]  = 32'h016C_5822;   // 0x044 sub
        mem[18]  = 32'h1000_FFFF;   // 0x048 beq -1
        mem[19]  = 32'h0800_0100;   // 0x04C j 0x100
        mem[256] = 32'h1000_0003;   // 0x400 beq +3
        mem[260] = 32'h8C08_0000;   // 0x410 lw
        mem[261] = 32'hAC09_0004;   // 0x414 sw

        reset = 1'b0; reset1 = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; stall = 1'b0;
        branch1 = 1'b0; zero1 = 1'b0; jump1 = 1'b0; stall1 = 1'b0;
        ackEn = 1'b1; forceAck = 1'b0; ackWait = 0;

        repeat (3) @(negedge clk);
        check("reset imem_req", 32'(imem_req), 32'd0);
        check("reset pc", pc, RESET_PC);
        check("reset instr_valid", 32'(instr_valid), 32'd0);
        check("reset instr", instr, 32'd0);
        check("reset fetch_err", 32'(fetch_err), 32'd0);

        reset = 1'b1;
        e.pc = RESET_PC;
        e.instr = memAt(RESET_PC);
        expQ.push_back(e);
        @(negedge clk);
        check("first req", 32'(imem_req), 32'd1);
        check("first addr", imem_addr, RESET_PC);
        awaitValid(2, "i0");
        finishInstr(RESET_PC, e.instr, 1'b0, 1'b0, 1'b0, 0, "i0");

        fetchStep(32'h44, 0, 3, 1'b0, 1'b0, 1'b0, 0, "i1");
        fetchStep(32'h48, 0, 3, 1'b1, 1'b1, 1'b0, 0, "beq taken");
        fetchStep(32'h48, 2, 5, 1'b1, 1'b0, 1'b0, 5, "beq not taken");
        fetchStep(32'h4C, 0, 3, 1'b1, 1'b1, 1'b1, 0, "jump over branch");
        fetchStep(32'h400, 0, 3, 1'b1, 1'b1, 1'b0, 0, "beq fwd");

`ifdef FETCH_TIMEOUT_EN
        ackEn = 1'b0;
        e.pc = 32'h410;
        e.instr = memAt(32'h410);
        expQ.push_back(e);
        n = 0;
        reqHigh = 0;
        do begin
            @(negedge clk);
            n++;
            if (imem_req) reqHigh++;
        end while (!fetch_err && n < 40);
        check("timeout fetch_err", 32'(fetch_err), 32'd1);
        check("timeout req cycles", 32'(reqHigh), 32'd5);
        check("timeout req drop", 32'(imem_req), 32'd0);
        ackEn = 1'b1;
        @(negedge clk);
        check("retry req", 32'(imem_req), 32'd1);
        check("retry addr", imem_addr, 32'h410);
        awaitValid(2, "retry");
        finishInstr(32'h410, e.instr, 1'b0, 1'b0, 1'b0, 0, "retry");
        check("fetch_err sticky", 32'(fetch_err), 32'd1);
`else
        fetchStep(32'h410, 3, 6, 1'b0, 1'b0, 1'b0, 0, "slow mem");
        check("fetch_err tied", 32'(fetch_err), 32'd0);
`endif

        fetchStep(32'h414, 0, 3, 1'b0, 1'b0, 1'b0, 0, "i7");
        ackEn = 1'b0;
        check("queue drained", 32'(expQ.size()), 32'd0);

        // High-region jump keeps pc_plus4[31:28]
        @(negedge clk);
        reset1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid1 && n < 40);
        check("u1 valid", 32'(instr_valid1), 32'd1);
        check("u1 pc", pc1, 32'h1000_0000);
        check("u1 instr", instr1, 32'h0800_0100);
        check("u1 op_code", 32'(op_code1), 32'd2);
        jump1 = 1'b1; branch1 = 1'b1; zero1 = 1'b1;
        @(negedge clk);
        check("u1 jump req", 32'(imem_req1), 32'd1);
        check("u1 jump addr", imem_addr1, 32'h1000_0400);
        jump1 = 1'b0; branch1 = 1'b0; zero1 = 1'b0;

        // Reset in the middle of a pending request
        repeat (2) @(negedge clk);
        check("pending req", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset req", 32'(imem_req), 32'd0);
        check("async reset pc", pc, RESET_PC);
        check("async reset valid", 32'(instr_valid), 32'd0);
        check("async reset fetch_err", 32'(fetch_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
